// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM encoding, PC width,
// reset vector default and the opcode/funct values decoder-side control keys on.
package instr_fetch_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    // Control-transfer encodings (opcode in [31:26], funct in [5:0])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FUNCT_JR   = 6'h08;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next fetch address: sequential pc+4 (wrapping modulo 2^32) or the
// word-aligned redirect target.
module pc_next
    import instr_fetch_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic            redirect,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] next_pc
);

    assign next_pc = redirect ? word_align(target) : pc + 32'd4;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding-request instruction fetch unit with redirect handling;
// a redirect that cannot cancel an in-flight read is parked until the ack.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_data_i,
    output logic [31:0]     instr_o,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus4_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i
);

    fetch_state_t    state, state_n;
    logic            req_n;
    logic [PC_W-1:0] addr_n;
    logic [PC_W-1:0] pending_pc, pending_n;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] next_pc;
    logic            capture;
    logic            drop_valid;

    pc_next u_pc_next (
        .pc       (pc_o),
        .redirect (redirect_i),
        .target   (redirect_pc_i),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_n    = state;
        req_n      = imem_req_o;
        addr_n     = imem_addr_o;
        pending_n  = pending_pc;
        capture    = 1'b0;
        drop_valid = 1'b0;
        case (state)
            ST_START: begin
                state_n = ST_FETCH;
                req_n   = 1'b1;
                addr_n  = fetch_pc;
            end
            ST_FETCH: begin
                if (imem_ack_i && redirect_i) begin
                    addr_n = next_pc;
                end else if (imem_ack_i) begin
                    capture = 1'b1;
                    req_n   = 1'b0;
                    state_n = ST_VALID;
                end else if (redirect_i) begin
                    // Read cannot be cancelled; keep it on the bus and park the target
                    pending_n = next_pc;
                    state_n   = ST_DRAIN;
                end
            end
            ST_VALID: begin
                if (redirect_i || instr_ready_i) begin
                    drop_valid = 1'b1;
                    req_n      = 1'b1;
                    addr_n     = next_pc;
                    state_n    = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (redirect_i) begin
                    pending_n = next_pc;
                end
                if (imem_ack_i) begin
                    addr_n  = redirect_i ? next_pc : pending_pc;
                    state_n = ST_FETCH;
                end
            end
            default: begin
                state_n = ST_START;
                req_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_START;
            imem_req_o    <= 1'b0;
            imem_addr_o   <= '0;
            pending_pc    <= '0;
            fetch_pc      <= RESET_PC;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            pc_o          <= '0;
            pc_plus4_o    <= '0;
        end else begin
            state       <= state_n;
            imem_req_o  <= req_n;
            imem_addr_o <= addr_n;
            pending_pc  <= pending_n;
            fetch_pc    <= addr_n;
            if (capture) begin
                instr_valid_o <= 1'b1;
                instr_o       <= imem_data_i;
                pc_o          <= imem_addr_o;
                pc_plus4_o    <= imem_addr_o + 32'd4;
            end else if (drop_valid) begin
                instr_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: reset, latency, backpressure, redirects,
// drain behaviour, PC wrap and reset during an outstanding request.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .instr_o       (instr),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full fetch/consume handshake starting in FETCH at exp_pc
    task automatic deliver(input logic [31:0] exp_pc, input logic [31:0] data);
        check_eq("dlv_req", {31'd0, imem_req}, 32'd1);
        check_eq("dlv_addr", imem_addr, exp_pc);
        imem_ack  = 1'b1;
        imem_data = data;
        tick();
        imem_ack = 1'b0;
        check_eq("dlv_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("dlv_instr", instr, data);
        check_eq("dlv_pc", pc, exp_pc);
        check_eq("dlv_pc4", pc_plus4, exp_pc + 32'd4);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("dlv_valid_drop", {31'd0, instr_valid}, 32'd0);
        check_eq("dlv_next_addr", imem_addr, exp_pc + 32'd4);
    endtask

    initial begin
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_data   = '0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset state
        tick();
        tick();
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_pc4", pc_plus4, 32'h0);

        // Release: one START cycle, then request at RESET_PC
        rst = 1'b0;
        tick();
        check_eq("first_req", {31'd0, imem_req}, 32'd1);
        check_eq("first_addr", imem_addr, 32'h0);

        // Zero-latency ack: valid the next cycle
        imem_ack  = 1'b1;
        imem_data = 32'h2008_0005;
        tick();
        imem_ack = 1'b0;
        check_eq("lat_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("lat_instr", instr, 32'h2008_0005);
        check_eq("lat_pc", pc, 32'h0);
        check_eq("lat_pc4", pc_plus4, 32'h4);
        check_eq("lat_req_low", {31'd0, imem_req}, 32'd0);

        // Backpressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("bp_instr", instr, 32'h2008_0005);
            check_eq("bp_pc", pc, 32'h0);
            check_eq("bp_req", {31'd0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("bp_rel_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("bp_rel_req", {31'd0, imem_req}, 32'd1);
        check_eq("bp_rel_addr", imem_addr, 32'h4);

        // In-order delivery up to 0x10
        deliver(32'h4, 32'h0000_0020);
        deliver(32'h8, 32'h0000_0021);
        deliver(32'hC, 32'h0000_0022);

        // Redirect in VALID with ready at pc 0x10, target 0x40
        check_eq("v10_addr", imem_addr, 32'h10);
        imem_ack  = 1'b1;
        imem_data = 32'h1000_0003;
        tick();
        imem_ack = 1'b0;
        check_eq("v10_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("v10_pc", pc, 32'h10);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        instr_ready = 1'b0;
        redirect    = 1'b0;
        check_eq("rv_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rv_req", {31'd0, imem_req}, 32'd1);
        check_eq("rv_addr", imem_addr, 32'h40);
        tick();
        check_eq("rv_no_valid", {31'd0, instr_valid}, 32'd0);

        // Redirect with ack in FETCH: data dropped, new address next cycle
        imem_ack    = 1'b1;
        imem_data   = 32'hBAD0_0001;
        redirect    = 1'b1;
        redirect_pc = 32'h23;
        tick();
        imem_ack = 1'b0;
        redirect = 1'b0;
        check_eq("rf_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rf_req", {31'd0, imem_req}, 32'd1);
        check_eq("rf_addr", imem_addr, 32'h20);

        // Redirect to 0x80 during FETCH at 0x20, ack 3 cycles later
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("dr_addr_hold", imem_addr, 32'h20);
            check_eq("dr_req_hold", {31'd0, imem_req}, 32'd1);
            check_eq("dr_no_valid", {31'd0, instr_valid}, 32'd0);
            if (i < 2) tick();
        end
        imem_ack  = 1'b1;
        imem_data = 32'hBAD0_0002;
        tick();
        imem_ack = 1'b0;
        check_eq("dr_end_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("dr_end_addr", imem_addr, 32'h80);
        tick();
        check_eq("dr_after_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("dr_after_addr", imem_addr, 32'h80);

        // Second redirect during DRAIN overrides the pending target
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_pc = 32'hC0;
        tick();
        redirect = 1'b0;
        check_eq("dr2_addr_hold", imem_addr, 32'h80);
        imem_ack  = 1'b1;
        imem_data = 32'hBAD0_0003;
        tick();
        imem_ack = 1'b0;
        check_eq("dr2_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("dr2_addr", imem_addr, 32'hC0);

        // Wrap: misaligned target near top of address space
        imem_ack    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        imem_ack = 1'b0;
        redirect = 1'b0;
        check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        deliver(32'hFFFF_FFFC, 32'h0C00_0010);
        check_eq("wrap_next", imem_addr, 32'h0);

        // Reset with a request outstanding, acks during and after reset ignored
        rst = 1'b1;
        tick();
        check_eq("mr_req", {31'd0, imem_req}, 32'd0);
        check_eq("mr_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack  = 1'b1;
        imem_data = 32'hBAD0_0004;
        tick();
        check_eq("mr_ack_valid", {31'd0, instr_valid}, 32'd0);
        rst = 1'b0;
        tick();
        imem_ack = 1'b0;
        check_eq("mr_start_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("mr_first_req", {31'd0, imem_req}, 32'd1);
        check_eq("mr_first_addr", imem_addr, 32'h0);
        tick();
        check_eq("mr_still_no_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("mr_instr_clear", instr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
